// File: rtl/aes_out_fifo.sv
// aes_out_fifo: synchronous output FIFO for the AES datapath.
// Stores 32-bit words from the AES output stage, tracks how many complete cipher
// blocks have been written, and delivers words to the consumer with a one-cycle
// registered read.
// Ports:
//   iClk, iRst_n           clock, asynchronous active-low reset
//   iClear                 synchronous flush of pointers, count, block state and flags
//   iBlockSize[3:0]        block-size code (8, 6 or 4 words)
//   iWrite_req, iData      write side; oAlmost_full, oFull give back-pressure
//   iRead_req              read side; oData/oData_valid arrive one cycle later
//   oEmpty, oUsedw         occupancy status
//   oBlock_done            one-cycle pulse after the write that completes a block
//   oBlock_count           saturating count of completed blocks
//   oOverflow              sticky: a write was dropped because the FIFO was full
module aes_out_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AF_THRESHOLD = 8
) (
   input  logic                       iClk,
   input  logic                       iRst_n,
   input  logic                       iClear,
   input  logic [3:0]                 iBlockSize,
   input  logic                       iWrite_req,
   input  logic [31:0]                iData,
   output logic                       oAlmost_full,
   output logic                       oFull,
   input  logic                       iRead_req,
   output logic                       oEmpty,
   output logic [31:0]                oData,
   output logic                       oData_valid,
   output logic [$clog2(DEPTH):0]     oUsedw,
   output logic                       oBlock_done,
   output logic [15:0]                oBlock_count,
   output logic                       oOverflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [2:0]    r_wib;
   logic [31:0]   r_data;
   logic          r_valid;
   logic          r_bdone;
   logic [15:0]   r_bcnt;
   logic          r_ovf;

   logic          w_full;
   logic          w_empty;
   logic          w_wr;
   logic          w_rd;
   logic [2:0]    w_blk_last;
   logic          w_blk_end;
   logic          w_unused_bs0;

   // Status flags come straight from the registered count
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign oFull        = w_full;
   assign oEmpty       = w_empty;
   assign oAlmost_full = (r_count >= CW'(AF_THRESHOLD));
   assign oUsedw       = r_count;

   // Accepted operations: no pass-through when full, no bypass when empty
   assign w_wr = iWrite_req & ~w_full;
   assign w_rd = iRead_req & ~w_empty;

   // Last word index of a block for the current size code
   always_comb begin
      w_blk_last = 3'd3;
      if (iBlockSize[3])
         w_blk_last = 3'd7;
      else if (iBlockSize[2] && iBlockSize[1])
         w_blk_last = 3'd5;
      else
         w_blk_last = 3'd3;
   end

   // >= so a size shrink mid-block completes on the next accepted write
   assign w_blk_end    = (r_wib >= w_blk_last);
   assign w_unused_bs0 = iBlockSize[0];

   // Storage array is deliberately not reset
   always_ff @(posedge iClk) begin
      if (w_wr && !iClear)
         r_mem[r_wr_ptr] <= iData;
   end

   // Pointers, count, read data and block tracking
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wib    <= '0;
         r_data   <= 32'h0;
         r_valid  <= 1'b0;
         r_bdone  <= 1'b0;
         r_bcnt   <= 16'h0;
         r_ovf    <= 1'b0;
      end else if (iClear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wib    <= '0;
         r_valid  <= 1'b0;
         r_bdone  <= 1'b0;
         r_bcnt   <= 16'h0;
         r_ovf    <= 1'b0;
      end else begin
         r_valid <= w_rd;
         r_bdone <= 1'b0;

         if (iWrite_req && w_full)
            r_ovf <= 1'b1;

         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_blk_end) begin
               r_wib   <= '0;
               r_bdone <= 1'b1;
               if (r_bcnt != 16'hFFFF)
                  r_bcnt <= r_bcnt + 16'd1;
            end else begin
               r_wib <= r_wib + 3'd1;
            end
         end

         if (w_rd) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end

         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign oData        = r_data;
   assign oData_valid  = r_valid;
   assign oBlock_done  = r_bdone;
   assign oBlock_count = r_bcnt;
   assign oOverflow    = r_ovf;

endmodule

// File: tb/tb_aes_out_fifo.sv
// tb_aes_out_fifo: directed, table-driven bench for aes_out_fifo (DEPTH=16, AF=8).
module tb_aes_out_fifo;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic [3:0]  bsize;
   logic        wr;
   logic [31:0] din;
   logic        af;
   logic        full;
   logic        rd;
   logic        empty;
   logic [31:0] dout;
   logic        valid;
   logic [4:0]  usedw;
   logic        bdone;
   logic [15:0] bcnt;
   logic        ovf;

   int n_pass;
   int n_tot;

   aes_out_fifo #(.DEPTH(16), .AF_THRESHOLD(8)) dut (
      .iClk         (clk),
      .iRst_n       (rst_n),
      .iClear       (clr),
      .iBlockSize   (bsize),
      .iWrite_req   (wr),
      .iData        (din),
      .oAlmost_full (af),
      .oFull        (full),
      .iRead_req    (rd),
      .oEmpty       (empty),
      .oData        (dout),
      .oData_valid  (valid),
      .oUsedw       (usedw),
      .oBlock_done  (bdone),
      .oBlock_count (bcnt),
      .oOverflow    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] din;
      logic [4:0]  usedw;
      logic        empty;
      logic        full;
      logic        af;
      logic        valid;
      logic [31:0] dout;
      logic        bdone;
      logic [15:0] bcnt;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Advance one clock; sample 1 ns after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] d);
      wr  = w;
      rd  = r;
      din = d;
   endtask

   task automatic do_clear();
      drive(1'b0, 1'b0, 32'h0);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   logic [31:0] q[$];
   logic [31:0] exp_word;

   initial begin
      n_pass = 0;
      n_tot  = 0;
      rst_n  = 1'b0;
      clr    = 1'b0;
      bsize  = 4'b1000;
      drive(1'b0, 1'b0, 32'h0);

      // 8-word block write/read, then read+write while empty
      for (int k = 0; k < 8; k++) begin
         vecs[k] = '{wr: 1'b1, rd: 1'b0, din: 32'(k + 1), usedw: 5'(k + 1),
                     empty: 1'b0, full: 1'b0, af: (k + 1 >= 8), valid: 1'b0,
                     dout: 32'h0, bdone: (k == 7), bcnt: (k == 7) ? 16'd1 : 16'd0};
      end
      for (int k = 0; k < 8; k++) begin
         vecs[8 + k] = '{wr: 1'b0, rd: 1'b1, din: 32'h0, usedw: 5'(7 - k),
                         empty: (k == 7), full: 1'b0, af: 1'b0, valid: 1'b1,
                         dout: 32'(k + 1), bdone: 1'b0, bcnt: 16'd1};
      end
      vecs[16] = '{wr: 1'b0, rd: 1'b0, din: 32'h0, usedw: 5'd0, empty: 1'b1, full: 1'b0,
                   af: 1'b0, valid: 1'b0, dout: 32'h8, bdone: 1'b0, bcnt: 16'd1};
      vecs[17] = '{wr: 1'b1, rd: 1'b1, din: 32'hAA, usedw: 5'd1, empty: 1'b0, full: 1'b0,
                   af: 1'b0, valid: 1'b0, dout: 32'h8, bdone: 1'b0, bcnt: 16'd1};
      vecs[18] = '{wr: 1'b0, rd: 1'b1, din: 32'h0, usedw: 5'd0, empty: 1'b1, full: 1'b0,
                   af: 1'b0, valid: 1'b1, dout: 32'hAA, bdone: 1'b0, bcnt: 16'd1};

      // Reset values while held in reset
      #3;
      chk("rst usedw", 32'(usedw), 32'd0);
      chk("rst empty", 32'(empty), 32'd1);
      chk("rst full",  32'(full),  32'd0);
      chk("rst af",    32'(af),    32'd0);
      chk("rst data",  dout,       32'h0);
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst bdone", 32'(bdone), 32'd0);
      chk("rst bcnt",  32'(bcnt),  32'd0);
      chk("rst ovf",   32'(ovf),   32'd0);
      #9 rst_n = 1'b1;
      cyc();

      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].rd, vecs[i].din);
         cyc();
         chk($sformatf("v%0d usedw", i), 32'(usedw), 32'(vecs[i].usedw));
         chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].empty));
         chk($sformatf("v%0d full",  i), 32'(full),  32'(vecs[i].full));
         chk($sformatf("v%0d af",    i), 32'(af),    32'(vecs[i].af));
         chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
         chk($sformatf("v%0d data",  i), dout,       vecs[i].dout);
         chk($sformatf("v%0d bdone", i), 32'(bdone), 32'(vecs[i].bdone));
         chk($sformatf("v%0d bcnt",  i), 32'(bcnt),  32'(vecs[i].bcnt));
      end
      drive(1'b0, 1'b0, 32'h0);

      // Full FIFO: simultaneous write+read drops the write, read still served
      do_clear();
      bsize = 4'b0100;
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 1'b0, 32'h100 + 32'(k));
         cyc();
      end
      drive(1'b0, 1'b0, 32'h0);
      chk("fill full",  32'(full),  32'd1);
      chk("fill usedw", 32'(usedw), 32'd16);
      chk("fill bcnt",  32'(bcnt),  32'd4);
      drive(1'b1, 1'b1, 32'hDEAD);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      chk("full rw data",  dout,       32'h100);
      chk("full rw valid", 32'(valid), 32'd1);
      chk("full rw ovf",   32'(ovf),   32'd1);
      chk("full rw usedw", 32'(usedw), 32'd15);
      chk("full rw bcnt",  32'(bcnt),  32'd4);
      for (int k = 1; k < 16; k++) begin
         drive(1'b0, 1'b1, 32'h0);
         cyc();
         chk($sformatf("drain%0d data", k), dout, 32'h100 + 32'(k));
      end
      drive(1'b0, 1'b0, 32'h0);
      chk("drain empty", 32'(empty), 32'd1);
      chk("drain ovf sticky", 32'(ovf), 32'd1);

      // 6-word blocks, then streaming with pointer wrap
      do_clear();
      chk("clr ovf", 32'(ovf), 32'd0);
      bsize = 4'b0110;
      q.delete();
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 1'b0, 32'h200 + 32'(k));
         q.push_back(32'h200 + 32'(k));
         cyc();
         if (k == 5 || k == 11)
            chk($sformatf("b6 bdone w%0d", k), 32'(bdone), 32'd1);
         else if (k == 6)
            chk("b6 bdone w6", 32'(bdone), 32'd0);
      end
      chk("b6 bcnt", 32'(bcnt), 32'd2);
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 1'b1, 32'h300 + 32'(k));
         q.push_back(32'h300 + 32'(k));
         exp_word = q.pop_front();
         cyc();
         chk($sformatf("wrap%0d valid", k), 32'(valid), 32'd1);
         chk($sformatf("wrap%0d data", k), dout, exp_word);
      end
      drive(1'b0, 1'b0, 32'h0);
      chk("wrap usedw", 32'(usedw), 32'd12);
      chk("wrap bcnt",  32'(bcnt),  32'd5);

      // Clear together with a write: write must be discarded
      do_clear();
      bsize = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, 32'h400 + 32'(k));
         cyc();
      end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 32'h0);
         cyc();
      end
      chk("pre clr usedw", 32'(usedw), 32'd3);
      chk("pre clr bcnt",  32'(bcnt),  32'd2);
      drive(1'b1, 1'b0, 32'hBAD);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      chk("clr usedw", 32'(usedw), 32'd0);
      chk("clr bcnt",  32'(bcnt),  32'd0);
      chk("clr ovf",   32'(ovf),   32'd0);
      chk("clr empty", 32'(empty), 32'd1);
      chk("clr valid", 32'(valid), 32'd0);
      drive(1'b1, 1'b0, 32'h55);
      cyc();
      drive(1'b0, 1'b1, 32'h0);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      chk("post clr data",  dout,       32'h55);
      chk("post clr valid", 32'(valid), 32'd1);

      // Asynchronous reset mid-burst at usedw=5
      do_clear();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b0, 32'h600 + 32'(k));
         cyc();
      end
      drive(1'b1, 1'b1, 32'h606);
      cyc();
      drive(1'b1, 1'b0, 32'h607);
      chk("pre rst usedw", 32'(usedw), 32'd6);
      chk("pre rst data",  dout,       32'h600);
      drive(1'b0, 1'b1, 32'h0);
      cyc();
      drive(1'b1, 1'b0, 32'h608);
      chk("pre rst usedw5", 32'(usedw), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst usedw", 32'(usedw), 32'd0);
      chk("arst empty", 32'(empty), 32'd1);
      chk("arst full",  32'(full),  32'd0);
      chk("arst af",    32'(af),    32'd0);
      chk("arst data",  dout,       32'h0);
      chk("arst valid", 32'(valid), 32'd0);
      chk("arst bdone", 32'(bdone), 32'd0);
      chk("arst bcnt",  32'(bcnt),  32'd0);
      chk("arst ovf",   32'(ovf),   32'd0);
      #3;
      drive(1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("post rst usedw", 32'(usedw), 32'd0);
      drive(1'b1, 1'b0, 32'h77);
      cyc();
      drive(1'b0, 1'b1, 32'h0);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      chk("post rst data", dout, 32'h77);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
